ob_cmd_issuer: RTL and testbench

- Host-side initiator for the order book: the other end of the book's command/response interface.
- Accepts commands from a host valid/ready port and drives the book's registered command port, honouring `cmd_full_r` and an in-flight cap.
- Pulls responses from the book into a 2-entry skid buffer and returns them to the host.
- Tracks outstanding commands, runs a no-progress watchdog and supports a drain/quiesce handshake.
- Design rule: every issued command produces exactly one response.

---
 rtl/ob_pkg.sv | 30 +++
 rtl/ob_cmd_issuer.sv | 194 +++++++++++++++++++
 tb/tb_ob_cmd_issuer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ob_pkg.sv
// Shared order-book command/response formats for the host-side issuer and the book.
// Both records are 64 bits so they travel as single flat words on the book interface.
package ob_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_CANCEL = 2'd1,
        OP_MODIFY = 2'd2,
        OP_QUERY  = 2'd3
    } op_t;

    typedef struct packed {
        op_t         op;
        logic        side;
        logic [12:0] oid;
        logic [31:0] price;
        logic [15:0] qty;
    } cmd_t;

    typedef struct packed {
        logic [3:0]  status;
        logic [11:0] oid;
        logic [31:0] price;
        logic [15:0] qty;
    } rsp_t;

    localparam int CMD_W = $bits(cmd_t);
    localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/ob_cmd_issuer.sv
// Host-side order-book initiator: host command -> registered book command (1 cycle), book response -> host via 2-entry skid (>=1 cycle).
// Backpressure: in_rdy drops on cmd_full_r, in-flight cap, drain or halt; rsp_accept drops when the skid buffer holds 2 entries.
module ob_cmd_issuer #(
    parameter int MAX_INFLIGHT   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [ob_pkg::CMD_W-1:0] in_cmd,
    output logic                     in_rdy,
    output logic                     cmd_vld_r,
    output logic [ob_pkg::CMD_W-1:0] cmd_r,
    input  logic                     cmd_full_r,
    input  logic                     rsp_vld,
    input  logic [ob_pkg::RSP_W-1:0] rsp,
    output logic                     rsp_accept,
    output logic                     out_vld,
    output logic [ob_pkg::RSP_W-1:0] out_rsp,
    input  logic                     out_accept,
    input  logic                     drain_req,
    output logic                     drain_done_r,
    input  logic                     clr_err,
    output logic [CNT_W-1:0]         inflight_r,
    output logic                     timeout_r,
    output logic                     err_unexp_rsp_r
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [ob_pkg::RSP_W-1:0]   r_skid [2];
    logic                       r_wr_ptr;
    logic                       r_rd_ptr;
    logic [1:0]                 r_occ;
    logic [WD_W-1:0]            r_wd_cnt;

    logic                       w_issue;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_rsp_expected;
    logic                       w_wd_inc;
    logic                       w_wd_fire;
    logic                       w_skid_empty;

    // in_rdy looks only at registered state plus the book's registered full flag.
    assign in_rdy         = (r_state == ST_RUN) & ~cmd_full_r
                          & (inflight_r < CNT_W'(MAX_INFLIGHT));
    assign w_issue        = in_vld & in_rdy;

    assign rsp_accept     = (r_occ != 2'd2);
    assign w_push         = rsp_vld & rsp_accept;
    assign w_skid_empty   = (r_occ == 2'd0);
    assign out_vld        = ~w_skid_empty;
    assign out_rsp        = r_skid[r_rd_ptr];
    assign w_pop          = out_vld & out_accept;

    assign w_rsp_expected = w_push & (inflight_r != '0);
    assign w_wd_inc       = (inflight_r != '0) & ~w_push;
    assign w_wd_fire      = w_wd_inc & (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_vld_r <= 1'b0;
            cmd_r     <= '0;
        end else begin
            cmd_vld_r <= w_issue;
            if (w_issue) begin
                cmd_r <= in_cmd;
            end
        end
    end

    // Two-entry FIFO; a pop at occupancy 2 only frees the slot for the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                r_skid[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_skid[r_wr_ptr] <= rsp;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // An unexpected response never decrements, so the count cannot underflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r <= '0;
        end else begin
            case ({w_issue, w_rsp_expected})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt <= '0;
        end else if (w_wd_fire || clr_err || !w_wd_inc) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    // Error set takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_r       <= 1'b0;
            err_unexp_rsp_r <= 1'b0;
        end else begin
            if (w_wd_fire) begin
                timeout_r <= 1'b1;
            end else if (clr_err) begin
                timeout_r <= 1'b0;
            end
            if (w_push && (inflight_r == '0)) begin
                err_unexp_rsp_r <= 1'b1;
            end else if (clr_err) begin
                err_unexp_rsp_r <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            drain_done_r <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            drain_done_r <= (w_state_nxt == ST_DRAINED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_wd_fire) begin
            w_state_nxt = ST_HALT;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (drain_req) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_req) begin
                        w_state_nxt = ST_RUN;
                    end else if ((inflight_r == '0) && w_skid_empty) begin
                        w_state_nxt = ST_DRAINED;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_req) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (clr_err) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ob_cmd_issuer.sv
// Bench for ob_cmd_issuer: per-cycle vector table plus directed skid, watchdog, drain and reset sequences.
// A negedge monitor scoreboards every command strobe and every delivered response.
module tb_ob_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [63:0] in_cmd;
    logic        in_rdy;
    logic        cmd_vld_r;
    logic [63:0] cmd_r;
    logic        cmd_full_r;
    logic        rsp_vld;
    logic [63:0] rsp;
    logic        rsp_accept;
    logic        out_vld;
    logic [63:0] out_rsp;
    logic        out_accept;
    logic        drain_req;
    logic        drain_done_r;
    logic        clr_err;
    logic [2:0]  inflight_r;
    logic        timeout_r;
    logic        err_unexp_rsp_r;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_cmd_q[$];
    logic [63:0] exp_rsp_q[$];
    bit          prev_hs = 1'b0;

    ob_cmd_issuer #(
        .MAX_INFLIGHT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_vld          (in_vld),
        .in_cmd          (in_cmd),
        .in_rdy          (in_rdy),
        .cmd_vld_r       (cmd_vld_r),
        .cmd_r           (cmd_r),
        .cmd_full_r      (cmd_full_r),
        .rsp_vld         (rsp_vld),
        .rsp             (rsp),
        .rsp_accept      (rsp_accept),
        .out_vld         (out_vld),
        .out_rsp         (out_rsp),
        .out_accept      (out_accept),
        .drain_req       (drain_req),
        .drain_done_r    (drain_done_r),
        .clr_err         (clr_err),
        .inflight_r      (inflight_r),
        .timeout_r       (timeout_r),
        .err_unexp_rsp_r (err_unexp_rsp_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change only at posedge+1, so at the negedge they show what the next edge samples.
    always @(negedge clk) begin
        if (!rst) begin
            exp_cmd_q.delete();
            exp_rsp_q.delete();
            prev_hs = 1'b0;
        end else begin
            chk("cmd_strobe", cmd_vld_r, prev_hs);
            if (cmd_vld_r) begin
                chk("cmd_q_nonempty", exp_cmd_q.size() != 0, 1);
                if (exp_cmd_q.size() != 0) chk("cmd_data", cmd_r, exp_cmd_q.pop_front());
            end
            if (out_vld && out_accept) begin
                chk("rsp_q_nonempty", exp_rsp_q.size() != 0, 1);
                if (exp_rsp_q.size() != 0) chk("rsp_order", out_rsp, exp_rsp_q.pop_front());
            end
            if (rsp_vld && rsp_accept) exp_rsp_q.push_back(rsp);
            prev_hs = in_vld && in_rdy;
            if (prev_hs) exp_cmd_q.push_back(in_cmd);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        logic       in_vld;
        logic       full;
        logic       rsp_vld;
        logic [2:0] exp_infl;
        logic       exp_rdy;
        logic       exp_cv;
        logic       exp_err;
    } vec_t;

    vec_t tbl[19];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        next_cycle();
        clr_err = 1'b0;
    endtask

    initial begin
        // Columns: in_vld, cmd_full_r, rsp_vld | inflight_r, in_rdy, cmd_vld_r, err_unexp_rsp_r
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};

        rst        = 1'b0;
        in_vld     = 1'b0;
        in_cmd     = '0;
        cmd_full_r = 1'b0;
        rsp_vld    = 1'b0;
        rsp        = '0;
        out_accept = 1'b1;
        drain_req  = 1'b0;
        clr_err    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_vld", cmd_vld_r, 0);
        chk("rst_cmd_r", cmd_r, 0);
        chk("rst_inflight", inflight_r, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_timeout", timeout_r, 0);
        chk("rst_err_unexp", err_unexp_rsp_r, 0);
        chk("rst_drain_done", drain_done_r, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_rsp_accept", rsp_accept, 1);
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            in_vld     = tbl[i].in_vld;
            cmd_full_r = tbl[i].full;
            rsp_vld    = tbl[i].rsp_vld;
            in_cmd     = {$urandom, $urandom};
            rsp        = {$urandom, $urandom};
            @(negedge clk);
            chk($sformatf("vec%0d_inflight", i), inflight_r, tbl[i].exp_infl);
            chk($sformatf("vec%0d_in_rdy", i), in_rdy, tbl[i].exp_rdy);
            chk($sformatf("vec%0d_cmd_vld", i), cmd_vld_r, tbl[i].exp_cv);
            chk($sformatf("vec%0d_err", i), err_unexp_rsp_r, tbl[i].exp_err);
            chk($sformatf("vec%0d_rsp_accept", i), rsp_accept, 1);
            next_cycle();
        end
        in_vld = 1'b0; rsp_vld = 1'b0; cmd_full_r = 1'b0;

        // Skid buffer: 2 outstanding, host stalled, 3 responses offered.
        clear_errors();
        out_accept = 1'b0;
        in_vld = 1'b1;
        in_cmd = {$urandom, $urandom}; next_cycle();
        in_cmd = {$urandom, $urandom}; next_cycle();
        in_vld = 1'b0;
        rsp_vld = 1'b1;
        rsp = 64'hA0A0_0000_0000_0001;
        @(negedge clk); chk("skid_acc0", rsp_accept, 1);
        next_cycle();
        rsp = 64'hB0B0_0000_0000_0002;
        @(negedge clk); chk("skid_acc1", rsp_accept, 1);
        next_cycle();
        rsp = 64'hC0C0_0000_0000_0003;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("skid_full_acc", rsp_accept, 0);
            chk("skid_full_out_vld", out_vld, 1);
            next_cycle();
        end
        out_accept = 1'b1;
        @(negedge clk); chk("skid_pop_same_cycle", rsp_accept, 0);
        next_cycle();
        @(negedge clk); chk("skid_reaccept", rsp_accept, 1);
        next_cycle();
        rsp_vld = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (out_vld && n < 10) begin @(negedge clk); n++; end
            chk("skid_drained", out_vld, 0);
        end
        chk("skid_inflight", inflight_r, 0);
        chk("skid_err_unexp", err_unexp_rsp_r, 1);

        // Watchdog: one command, no response.
        next_cycle();
        clear_errors();
        @(negedge clk); chk("clr_err_unexp", err_unexp_rsp_r, 0);
        next_cycle();
        in_vld = 1'b1; in_cmd = {$urandom, $urandom};
        next_cycle();
        in_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); chk("wd_not_early", timeout_r, 0);
        begin
            int n = 0;
            while (!timeout_r && n < 15) begin @(negedge clk); n++; end
            chk("wd_timeout", timeout_r, 1);
        end
        chk("wd_halt_rdy", in_rdy, 0);
        next_cycle();
        rsp_vld = 1'b1; rsp = {$urandom, $urandom};
        next_cycle();
        rsp_vld = 1'b0;
        @(negedge clk);
        chk("halt_rsp_inflight", inflight_r, 0);
        chk("halt_timeout_sticky", timeout_r, 1);
        chk("halt_rdy", in_rdy, 0);
        next_cycle();
        clear_errors();
        @(negedge clk);
        chk("clr_timeout", timeout_r, 0);
        chk("clr_run_rdy", in_rdy, 1);
        next_cycle();

        // Drain: 3 outstanding then drain_req while the host keeps offering.
        in_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin in_cmd = {$urandom, $urandom}; next_cycle(); end
        in_vld = 1'b0;
        drain_req = 1'b1;
        next_cycle();
        in_vld = 1'b1; in_cmd = {$urandom, $urandom};
        @(negedge clk); chk("drain_rdy", in_rdy, 0);
        chk("drain_not_done", drain_done_r, 0);
        next_cycle();
        rsp_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin rsp = {$urandom, $urandom}; next_cycle(); end
        rsp_vld = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!drain_done_r && n < 10) begin @(negedge clk); n++; end
            chk("drain_done", drain_done_r, 1);
        end
        chk("drain_inflight", inflight_r, 0);
        chk("drain_rdy_held", in_rdy, 0);
        next_cycle();
        in_vld = 1'b0; drain_req = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("undrain_done", drain_done_r, 0);
        chk("undrain_rdy", in_rdy, 1);
        in_vld = 1'b1; in_cmd = {$urandom, $urandom};
        next_cycle();
        in_vld = 1'b0;
        @(negedge clk); chk("undrain_issue", inflight_r, 1);
        next_cycle();

        // Reset mid-operation discards a buffered response.
        out_accept = 1'b0;
        rsp_vld = 1'b1; rsp = {$urandom, $urandom};
        next_cycle();
        rsp_vld = 1'b0;
        @(negedge clk); chk("pre_rst_out_vld", out_vld, 1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_vld", out_vld, 0);
        chk("mid_rst_inflight", inflight_r, 0);
        next_cycle();
        rst = 1'b1;
        out_accept = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("post_rst_out_vld", out_vld, 0);
        chk("cmd_q_empty", exp_cmd_q.size(), 0);
        chk("rsp_q_empty", exp_rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
